instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch unit feeding the single-cycle datapath. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. Each fetched word is presented to decode and the control unit through a valid/ready handshake. It consumes the control unit's `Branch` and `jump` decisions, together with the ALU `zero` flag, to select the next PC.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `COUNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  instruction memory read request.
- `imem_addr`  out  32  byte address of the read; always equals `pc`.
- `imem_ack`  in  1  read data valid on `imem_rdata`; ignored outside FETCH.
- `imem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  `instruction`/`instr_pc` hold a fetched word.
- `instr_ready`  in  1  decode accepts the word.
- `instruction`  out  32  fetched word; bits [31:26] drive the control unit opcode input.
- `instr_pc`  out  32  address of `instruction`.
- `Branch`  in  1  from control unit; sampled only on the accept cycle.
- `jump`  in  1  from control unit; sampled only on the accept cycle.
- `zero`  in  1  ALU zero flag; sampled only on the accept cycle.
- `retired`  out  COUNT_W  count of accepted instructions.
- `halted`  out  1  high in HALT; present only with `IFU_HALT_EN`, otherwise tied 0.

## Operation
- States: IDLE, FETCH, HOLD, HALT.
- IDLE
  - Entered by reset.
  - Moves to FETCH on the first clock edge with `reset` low.
- FETCH
  - `imem_req`=1, `imem_addr`=`pc`; both stay stable until `imem_ack`.
  - On `imem_ack`: capture `imem_rdata` into `instruction` and `pc` into `instr_pc`, then go to HOLD.
- HOLD
  - `instr_valid`=1; `instruction` and `instr_pc` stay stable.
  - Accept = `instr_valid & instr_ready`. On accept:
    - `retired` increments.
    - `pc` loads the next PC.
    - The FSM returns to FETCH.
- Next-PC rules, evaluated on accept, in priority order. Let `pc4 = instr_pc + 4`, mod 2^32.
  - `jump`=1 -> `{pc4[31:28], instruction[25:0], 2'b00}`.
  - else `Branch & zero` -> `pc4 + {{14{instruction[15]}}, instruction[15:0], 2'b00}`, mod 2^32.
  - else -> `pc4`.
- Opcode 6'b000000 (nop) is fetched and retired like any other word.
- `retired` wraps from all-ones to 0.
- Boundaries:
  - `imem_ack` in IDLE, HOLD or HALT is ignored.
  - `instr_ready` without `instr_valid` has no effect.
  - `Branch`, `jump` and `zero` are ignored outside the accept cycle.
  - Reset asserted mid-transaction:
    - Any request is abandoned; `imem_req` drops immediately.
    - `pc` returns to `RESET_PC`.
    - A held instruction is discarded and not counted.
  - PC wrap past 32'hFFFF_FFFC yields 32'h0000_0000.

## Timing
- Reset values:
  - state IDLE; `pc`=`RESET_PC`.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `instr_valid`=0, `instruction`=0, `instr_pc`=0.
  - `retired`=0, `halted`=0.
- `imem_ack` may arrive in the same cycle `imem_req` rises (zero-wait memory).
- Ack in cycle N -> `instr_valid`=1 in N+1.
- Accept in cycle M -> `imem_req`=1 with the new `imem_addr` in M+1.
- Best-case throughput: one instruction per 2 cycles.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.

## Configuration
- Macro `IFU_HALT_EN`.
- Defined:
  - An accepted word with opcode 6'b111111 is retired (`retired` increments).
  - The FSM then enters HALT instead of FETCH; `pc` still updates per the next-PC rules.
  - In HALT: `halted`=1, `imem_req`=0, `instr_valid`=0.
  - Only `reset` exits HALT.
- Undefined:
  - Opcode 6'b111111 is treated as an ordinary instruction.
  - No HALT state exists; `halted` is constant 0.

## Test plan
- Reset release, zero-wait memory, `instr_ready`=1, no branch/jump -> `imem_addr` sequence 0x0, 0x4, 0x8.
  - `instr_valid` pulses every 2nd cycle.
  - `retired`=3 after the third accept.
- Memory ack delayed 3 cycles, `instr_ready` held low 2 cycles -> `imem_addr` stable during the wait.
  - `instruction` stable while `instr_valid`=1.
  - Exactly one `retired` increment.
- Word 0x1000_FFFF at 0x10 accepted with `Branch`=1, `zero`=1 -> next `imem_addr`=0x10.
  - Same word with `zero`=0 -> next `imem_addr`=0x14.
- Word 0x0800_0040 at 0x1000_0000 accepted with `jump`=1 and `Branch`=1 -> next `imem_addr`=0x1000_0100 (jump wins).
- `reset` pulsed while `imem_req`=1 with address 0x20 -> `imem_req`=0 immediately.
  - After release, first `imem_addr`=`RESET_PC`; `retired`=0.
- With `IFU_HALT_EN`: accept opcode 6'b111111 at 0x8 -> `halted`=1, `imem_req` stays 0, `retired` increments by 1.
  - Without the macro: the next fetch is at 0xC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Program counter and instruction fetch over req/ack, with a
//               valid/ready hand-off to decode. Optional HALT state when the
//               IFU_HALT_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [31:0]        instruction,
    output logic [31:0]        instr_pc,
    input  logic               Branch,
    input  logic               jump,
    input  logic               zero,
    output logic [COUNT_W-1:0] retired,
    output logic               halted
);

`ifdef IFU_HALT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HOLD, ST_HALT} state_t;
    localparam logic [5:0] c_halt_op = 6'b111111;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HOLD} state_t;
`endif

    localparam logic [COUNT_W-1:0] c_one = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_next;
    logic [31:0]        r_pc;
    logic [31:0]        r_instr;
    logic [31:0]        r_instr_pc;
    logic [COUNT_W-1:0] r_retired;

    logic               w_capture;
    logic               w_accept;
    logic [31:0]        w_pc4;
    logic [31:0]        w_jump_target;
    logic [31:0]        w_branch_off;
    logic [31:0]        w_next_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // HOLD is the only state with instr_valid high, so accept needs only ready.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_FETCH;
`ifdef IFU_HALT_EN
                    if (r_instr[31:26] == c_halt_op) begin
                        w_state_next = ST_HALT;
                    end
`endif
                end
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
    end

    always_comb begin
        w_pc4         = r_instr_pc + 32'd4;
        w_jump_target = {w_pc4[31:28], r_instr[25:0], 2'b00};
        w_branch_off  = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
        if (jump) begin
            w_next_pc = w_jump_target;
        end else if (Branch & zero) begin
            w_next_pc = w_pc4 + w_branch_off;
        end else begin
            w_next_pc = w_pc4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_instr    <= 32'd0;
            r_instr_pc <= 32'd0;
            r_retired  <= '0;
        end else begin
            if (w_capture) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
            end
            if (w_accept) begin
                r_pc      <= w_next_pc;
                r_retired <= r_retired + c_one;
            end
        end
    end

    assign imem_req    = (r_state == ST_FETCH);
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == ST_HOLD);
    assign instruction = r_instr;
    assign instr_pc    = r_instr_pc;
    assign retired     = r_retired;

`ifdef IFU_HALT_EN
    assign halted = (r_state == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Randomized and directed bench for instr_fetch_unit against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFU_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        Branch = 1'b0;
    logic        jump = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] retired;
    logic        halted;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .COUNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .instr_pc(instr_pc),
        .Branch(Branch), .jump(jump), .zero(zero),
        .retired(retired), .halted(halted)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 awaiting memory, 2 word on offer, 3 halted
    int          m_phase;
    logic [31:0] m_pc, m_instr, m_ipc, m_ret;

    function automatic logic [31:0] model_next_pc(input logic [31:0] ipc, input logic [31:0] w,
                                                   input bit br, input bit jp, input bit z);
        logic [31:0] seq;
        int          off;
        seq = ipc + 32'd4;
        if (jp) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
        if (br && z) begin
            off = int'($signed(w[15:0]));
            return seq + 32'(off * 4);
        end
        return seq;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_pc    = RESET_PC;
        m_instr = 32'd0;
        m_ipc   = 32'd0;
        m_ret   = 32'd0;
    endtask

    task automatic check_outputs(input string where);
        check({where, "/req"},    32'(imem_req),    32'(m_phase == 1));
        check({where, "/addr"},   imem_addr,        m_pc);
        check({where, "/valid"},  32'(instr_valid), 32'(m_phase == 2));
        check({where, "/instr"},  instruction,      m_instr);
        check({where, "/ipc"},    instr_pc,         m_ipc);
        check({where, "/ret"},    retired,          m_ret);
        check({where, "/halted"}, 32'(halted),      32'(m_phase == 3));
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic step(input bit ack, input bit rdy, input bit br, input bit jp, input bit z,
                        input logic [31:0] word, input string where);
        imem_ack = ack; imem_rdata = word; instr_ready = rdy;
        Branch = br; jump = jp; zero = z;
        @(posedge clk);
        case (m_phase)
            0: m_phase = 1;
            1: if (ack) begin
                   m_instr = word;
                   m_ipc   = m_pc;
                   m_phase = 2;
               end
            2: if (rdy) begin
                   m_ret   = m_ret + 32'd1;
                   m_pc    = model_next_pc(m_ipc, m_instr, br, jp, z);
                   m_phase = (HALT_EN && m_instr[31:26] == 6'h3f) ? 3 : 1;
               end
            default: ;
        endcase
        @(negedge clk);
        check_outputs(where);
    endtask

    task automatic pulse_reset(input string where);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check({where, "/req_drop"}, 32'(imem_req), 32'd0);
        check_outputs({where, "/in_reset"});
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One fetch (ack with word) followed by an accept with the given controls.
    task automatic fetch_accept(input logic [31:0] word, input bit br, input bit jp, input bit z,
                                input string where);
        step(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), word, {where, "/fetch"});
        step(1'($urandom), 1'b1, br, jp, z, $urandom, {where, "/accept"});
    endtask

    logic [31:0] ret_before;

    initial begin
        model_reset();
        #1;
        check_outputs("reset_state");
        @(negedge clk);
        reset = 1'b0;

        // Ack while idle is ignored; sequential fetch 0x0, 0x4, 0x8
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, "idle");
        for (int i = 0; i < 3; i++) begin
            check("seq_addr", imem_addr, 32'(i * 4));
            fetch_accept(32'd0, 1'b0, 1'b0, 1'b0, "seq");
        end
        check("seq_retired", retired, 32'd3);
        fetch_accept(32'h0000_0000, 1'b0, 1'b0, 1'b0, "nop_c");

        // Branch at 0x10, taken then not taken
        fetch_accept(32'h1000_FFFF, 1'b1, 1'b0, 1'b1, "br_taken");
        check("br_taken_addr", imem_addr, 32'h0000_0010);
        fetch_accept(32'h1000_FFFF, 1'b1, 1'b0, 1'b0, "br_not");
        check("br_not_addr", imem_addr, 32'h0000_0014);

        // Branch to the top word, then wrap to zero
        fetch_accept(32'h1000_FFF9, 1'b1, 1'b0, 1'b1, "br_top");
        check("br_top_addr", imem_addr, 32'hFFFF_FFFC);
        fetch_accept(32'h0000_0000, 1'b0, 1'b0, 1'b0, "wrap");
        check("wrap_addr", imem_addr, 32'h0000_0000);

        // Jump beats branch
        fetch_accept(32'h0800_0040, 1'b1, 1'b1, 1'b1, "jump");
        check("jump_addr", imem_addr, 32'h0000_0100);

        // Slow memory and stalled decode
        ret_before = retired;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, $urandom, "wait_mem");
            check("wait_addr", imem_addr, 32'h0000_0100);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0123_4567, "late_ack");
        for (int i = 0; i < 2; i++) begin
            step(1'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, "stall");
            check("stall_instr", instruction, 32'h0123_4567);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $urandom, "stall_accept");
        check("stall_retired", retired, ret_before + 32'd1);

        // Reset during an outstanding request
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, "pre_rst");
        pulse_reset("mid_fetch");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, "post_rst");
        check("post_rst_addr", imem_addr, RESET_PC);
        check("post_rst_ret", retired, 32'd0);

        // Opcode 6'b111111 at 0x8
        fetch_accept(32'd0, 1'b0, 1'b0, 1'b0, "h0");
        fetch_accept(32'd0, 1'b0, 1'b0, 1'b0, "h1");
        fetch_accept(32'hFC00_0000, 1'b0, 1'b0, 1'b0, "halt_op");
        check("halt_ret", retired, 32'd3);
        if (HALT_EN) begin
            for (int i = 0; i < 3; i++) begin
                step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, $urandom, "halted");
                check("halt_flag", 32'(halted), 32'd1);
                check("halt_req", 32'(imem_req), 32'd0);
            end
        end else begin
            check("nohalt_addr", imem_addr, 32'h0000_000C);
        end
        pulse_reset("after_halt");

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(149) == 0) begin
                pulse_reset("rand_rst");
            end else begin
                step(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(7) == 0),
                     1'($urandom), $urandom, "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
